// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Brief   : Shared state encoding and datapath select codes for the prefetch cache.
// Revision: 1.0
// ============================================================================
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WB       = 3'd2,
        ST_FETCH    = 3'd3,
        ST_PF_CHECK = 3'd4,
        ST_PF_WB    = 3'd5,
        ST_PF_FILL  = 3'd6
    } state_t;

    localparam logic [1:0] DIN_PMEM = 2'b00;
    localparam logic [1:0] DIN_CPU  = 2'b01;
    localparam logic [1:0] DIN_PF   = 2'b11;

    localparam logic [1:0] WE_NONE  = 2'b00;
    localparam logic [1:0] WE_LINE  = 2'b01;
    localparam logic [1:0] WE_BYTE  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/prefetch_cache_control.sv
`default_nettype none
// ============================================================================
// Module  : prefetch_cache_control
// Brief   : Control FSM for the 2-way prefetch cache; CPU traffic beats prefetch.
// Revision: 1.0
// ============================================================================
module prefetch_cache_control
    import cache_pkg::*;
#(
    parameter bit PF_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    input  logic       prefetch_ready,
    output logic       pf_ack,
    input  logic       miss,
    input  logic       way,
    input  logic       dirty_out,
    output logic [1:0] data_in_sel,
    output logic       pmem_addr_sel,
    output logic [1:0] wr_en_data_0_sel,
    output logic [1:0] wr_en_data_1_sel,
    output logic       dirty_in,
    output logic       valid_in,
    output logic       ld_dirty_0,
    output logic       ld_dirty_1,
    output logic       ld_valid_0,
    output logic       ld_valid_1,
    output logic       ld_tag_0,
    output logic       ld_tag_1,
    output logic       ld_lru,
    output logic       index_sel,
    output logic       tag_sel
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] w_we;
    logic       w_ld_dirty;
    logic       w_ld_valid;
    logic       w_ld_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pf_ack        = 1'b0;
        data_in_sel   = DIN_PMEM;
        pmem_addr_sel = 1'b0;
        dirty_in      = 1'b0;
        valid_in      = 1'b0;
        ld_lru        = 1'b0;
        index_sel     = 1'b0;
        tag_sel       = 1'b0;
        w_we          = WE_NONE;
        w_ld_dirty    = 1'b0;
        w_ld_valid    = 1'b0;
        w_ld_tag      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    w_state_next = ST_CHECK;
                end else if (PF_ENABLE && prefetch_ready) begin
                    w_state_next = ST_PF_CHECK;
                end
            end

            ST_CHECK: begin
                if (!(mem_read || mem_write)) begin
                    w_state_next = ST_IDLE;
                end else if (!miss) begin
                    mem_resp     = 1'b1;
                    ld_lru       = 1'b1;
                    w_state_next = ST_IDLE;
                    // Write wins when both request lines are up.
                    if (mem_write) begin
                        data_in_sel = DIN_CPU;
                        w_we        = WE_BYTE;
                        w_ld_dirty  = 1'b1;
                        dirty_in    = 1'b1;
                    end
                end else begin
                    w_state_next = dirty_out ? ST_WB : ST_FETCH;
                end
            end

            ST_WB: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    data_in_sel  = DIN_PMEM;
                    w_we         = WE_LINE;
                    w_ld_tag     = 1'b1;
                    w_ld_valid   = 1'b1;
                    valid_in     = 1'b1;
                    w_ld_dirty   = 1'b1;
                    w_state_next = ST_CHECK;
                end
            end

            ST_PF_CHECK: begin
                index_sel = 1'b1;
                tag_sel   = 1'b1;
                if (!miss) begin
                    pf_ack       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = dirty_out ? ST_PF_WB : ST_PF_FILL;
                end
            end

            ST_PF_WB: begin
                index_sel  = 1'b1;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_state_next = ST_PF_FILL;
                end
            end

            ST_PF_FILL: begin
                // No LRU update: the prefetched line remains the next victim.
                index_sel    = 1'b1;
                tag_sel      = 1'b1;
                data_in_sel  = DIN_PF;
                w_we         = WE_LINE;
                w_ld_tag     = 1'b1;
                w_ld_valid   = 1'b1;
                valid_in     = 1'b1;
                w_ld_dirty   = 1'b1;
                pf_ack       = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_en_data_0_sel = way ? WE_NONE : w_we;
    assign wr_en_data_1_sel = way ? w_we    : WE_NONE;
    assign ld_dirty_0       = w_ld_dirty & ~way;
    assign ld_dirty_1       = w_ld_dirty &  way;
    assign ld_valid_0       = w_ld_valid & ~way;
    assign ld_valid_1       = w_ld_valid &  way;
    assign ld_tag_0         = w_ld_tag   & ~way;
    assign ld_tag_1         = w_ld_tag   &  way;

endmodule
`default_nettype wire
